// File: rtl/lsu_mmio_hs.sv
// Handshaked load/store unit: data RAM, MMIO peripherals, synchronised switches.
// Build option LSU_MISALIGN_TRAP_EN: fault misaligned H/W instead of aligning down.
module lsu_mmio_hs #(
    parameter int DMEM_BYTES = 2048,
    parameter int LEDR_W     = 17,
    parameter int LEDG_W     = 8,
    parameter int SW_W       = 18,
    parameter int SW_SYNC    = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req,
    output logic            o_ready,
    input  logic            i_lsu_wren,
    input  logic [31:0]     i_lsu_addr,
    input  logic [2:0]      i_type_access,
    input  logic [31:0]     i_st_data,
    output logic            o_rvalid,
    output logic [31:0]     o_ld_data,
    output logic            o_fault,
    output logic [31:0]     o_io_ledr,
    output logic [31:0]     o_io_ledg,
    output logic [6:0]      o_io_hex0,
    output logic [6:0]      o_io_hex1,
    output logic [6:0]      o_io_hex2,
    output logic [6:0]      o_io_hex3,
    output logic [6:0]      o_io_hex4,
    output logic [6:0]      o_io_hex5,
    output logic [6:0]      o_io_hex6,
    output logic [6:0]      o_io_hex7,
    output logic [31:0]     o_io_lcd,
    input  logic [SW_W-1:0] i_io_sw
);

    localparam int AW    = $clog2(DMEM_BYTES);
    localparam int WORDS = DMEM_BYTES / 4;
    localparam logic [31:0] LEDR_MASK =
        (LEDR_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << LEDR_W) - 64'd1);
    localparam logic [31:0] LEDG_MASK =
        (LEDG_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << LEDG_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, data_q;
    logic [2:0]      type_q;
    logic            wren_q;
    logic [31:0]     ledr_q, ledg_q, hexl_q, hexh_q, lcd_q;
    logic [31:0]     per_q, ram_q, per_rd, sw_ext;
    logic [SW_W-1:0] sw_q [SW_SYNC];
    logic [31:0]     mem [WORDS];

    logic [19:0]     page;
    logic            sel_ram, sel_ledr, sel_ledg, sel_hexl, sel_hexh;
    logic            sel_lcd, sel_sw, mapped, illegal, fault;
    logic            is_h, is_w, we;
    logic [1:0]      off;
    logic [3:0]      be;
    logic [31:0]     wdata, bm, raw, sh, ld;
    logic [AW-3:0]   idx;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q <= '0;
            data_q <= '0;
            type_q <= '0;
            wren_q <= 1'b0;
        end else if (state_q == IDLE && i_req) begin
            addr_q <= i_lsu_addr;
            data_q <= i_st_data;
            type_q <= i_type_access;
            wren_q <= i_lsu_wren;
        end
    end

    assign idx    = addr_q[AW-1:2];
    assign sw_ext = 32'(sw_q[SW_SYNC-1]);

    always_comb begin
        page     = addr_q[31:12];
        sel_ram  = addr_q[31:AW] == '0;
        sel_ledr = page == 20'h10000;
        sel_ledg = page == 20'h10001;
        sel_hexl = page == 20'h10002;
        sel_hexh = page == 20'h10003;
        sel_lcd  = page == 20'h10004;
        sel_sw   = page == 20'h10010;
        mapped   = sel_ram | sel_ledr | sel_ledg | sel_hexl
                 | sel_hexh | sel_lcd | sel_sw;
        is_h     = type_q[1:0] == 2'b01;
        is_w     = type_q[1:0] == 2'b10;
        illegal  = (type_q == 3'b011) | (type_q[2:1] == 2'b11);
        fault    = illegal | ~mapped | (wren_q & sel_sw);
`ifdef LSU_MISALIGN_TRAP_EN
        off   = addr_q[1:0];
        fault = fault | (is_h & addr_q[0])
              | (is_w & (addr_q[1:0] != 2'b00));
`else
        // misaligned H/W silently align down to their natural boundary
        off = is_w ? 2'b00 : {addr_q[1], addr_q[0] & ~is_h};
`endif
        be    = '0;
        wdata = '0;
        unique case (1'b1)
            is_w: begin
                be    = 4'hF;
                wdata = data_q;
            end
            is_h: begin
                be    = 4'b0011 << off;
                wdata = {2{data_q[15:0]}};
            end
            default: begin
                be    = 4'b0001 << off;
                wdata = {4{data_q[7:0]}};
            end
        endcase
        bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        we = (state_q == ACCESS) & wren_q & ~fault;
    end

    always_comb begin
        per_rd = '0;
        unique case (1'b1)
            sel_ledr: per_rd = ledr_q;
            sel_ledg: per_rd = ledg_q;
            sel_hexl: per_rd = hexl_q;
            sel_hexh: per_rd = hexh_q;
            sel_lcd:  per_rd = lcd_q;
            sel_sw:   per_rd = sw_ext;
            default:  per_rd = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_q <= '0;
            ledg_q <= '0;
            hexl_q <= '0;
            hexh_q <= '0;
            lcd_q  <= '0;
            per_q  <= '0;
        end else begin
            if (state_q == ACCESS) per_q <= per_rd;
            if (we) begin
                if (sel_ledr) ledr_q <= ((ledr_q & ~bm) | (wdata & bm)) & LEDR_MASK;
                if (sel_ledg) ledg_q <= ((ledg_q & ~bm) | (wdata & bm)) & LEDG_MASK;
                if (sel_hexl) hexl_q <= (hexl_q & ~bm) | (wdata & bm);
                if (sel_hexh) hexh_q <= (hexh_q & ~bm) | (wdata & bm);
                if (sel_lcd)  lcd_q  <= (lcd_q & ~bm) | (wdata & bm);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < SW_SYNC; i++) sw_q[i] <= '0;
        end else begin
            sw_q[0] <= i_io_sw;
            for (int i = 1; i < SW_SYNC; i++) sw_q[i] <= sw_q[i-1];
        end
    end

    // RAM has no reset so it can map onto block memory
    always_ff @(posedge i_clk) begin
        if (state_q == ACCESS) begin
            ram_q <= mem[idx];
            if (we && sel_ram) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        raw = sel_ram ? ram_q : per_q;
        sh  = raw >> {off, 3'b000};
        unique case (type_q)
            3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ld = {24'b0, sh[7:0]};
            3'b101:  ld = {16'b0, sh[15:0]};
            default: ld = sh;
        endcase
    end

    assign o_ready   = state_q == IDLE;
    assign o_rvalid  = state_q == RESP;
    assign o_ld_data = (o_rvalid & ~wren_q & ~fault) ? ld : '0;
    assign o_fault   = o_rvalid & fault;
    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hexl_q[6:0];
    assign o_io_hex1 = hexl_q[14:8];
    assign o_io_hex2 = hexl_q[22:16];
    assign o_io_hex3 = hexl_q[30:24];
    assign o_io_hex4 = hexh_q[6:0];
    assign o_io_hex5 = hexh_q[14:8];
    assign o_io_hex6 = hexh_q[22:16];
    assign o_io_hex7 = hexh_q[30:24];

endmodule
